// File: rtl/spk_buf_pingpong_ctrl.sv
// Ping-pong sequencer for one simple-dual-port spike BRAM: the producer fills one bank
// while the consumer drains the other; banks swap once both sides finish a timestep.
module spk_buf_pingpong_ctrl #(
  parameter int WORDS     = 32,
  parameter int RAM_WIDTH = 32,
  parameter int T_STEPS   = 25,
  parameter int RAM_DEPTH = 2 * WORDS,
  parameter int ADDR_W    = $clog2(RAM_DEPTH),
  parameter int TS_W      = $clog2(T_STEPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 prod_valid,
  input  logic [RAM_WIDTH-1:0] prod_data,
  output logic                 prod_ready,
  input  logic                 cons_req,
  output logic                 cons_valid,
  output logic [RAM_WIDTH-1:0] cons_data,
  output logic                 cons_last,
  output logic                 bram_wren,
  output logic [ADDR_W-1:0]    bram_wraddr,
  output logic [RAM_WIDTH-1:0] bram_wrdat,
  output logic                 bram_ren,
  output logic [ADDR_W-1:0]    bram_raddr,
  input  logic [RAM_WIDTH-1:0] bram_rdat,
  output logic                 busy,
  output logic                 done,
  output logic [TS_W-1:0]      rd_ts
);

  localparam int                CNT_W    = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(WORDS - 1);
  localparam logic [TS_W-1:0]   TS_LAST  = TS_W'(T_STEPS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if ((WORDS < 1) || ((WORDS & (WORDS - 1)) != 0)) begin : g_bad_words
    $error("spk_buf_pingpong_ctrl: WORDS must be a power of two");
  end
  if (T_STEPS < 1) begin : g_bad_tsteps
    $error("spk_buf_pingpong_ctrl: T_STEPS must be >= 1");
  end
  if (RAM_DEPTH != 2 * WORDS) begin : g_bad_depth
    $error("spk_buf_pingpong_ctrl: RAM_DEPTH must hold exactly two banks");
  end

  logic [2:0]       state_q, state_d;
  logic             wbank_q, wbank_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;
  logic [TS_W-1:0]  produced_q, produced_d;
  logic [TS_W-1:0]  rd_ts_q, rd_ts_d;
  logic             cons_valid_q, cons_valid_d;
  logic             cons_last_q, cons_last_d;

  logic              wr_open, rd_open, wr_hs, rd_hs, swap;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Both flags are registered, so the cycle where they are both high is itself the swap
  // cycle: wr_open and rd_open are already low there without any extra gating.
  always_comb begin
    wr_open = ((state_q == S_FILL) || (state_q == S_RUN)) && !wr_done_q;
    rd_open = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !rd_done_q;
    wr_hs   = wr_open && prod_valid;
    rd_hs   = rd_open && cons_req;
    wr_addr = (ADDR_W'(wbank_q) << (ADDR_W - 1)) | (ADDR_W'(wr_cnt_q) & LOW_MASK);
    rd_addr = (ADDR_W'(~wbank_q) << (ADDR_W - 1)) | (ADDR_W'(rd_cnt_q) & LOW_MASK);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wbank_d      = wbank_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wr_done_d    = wr_done_q;
    rd_done_d    = rd_done_q;
    produced_d   = produced_q;
    rd_ts_d      = rd_ts_q;
    cons_valid_d = rd_hs;
    cons_last_d  = rd_hs && (rd_cnt_q == LAST_IDX);
    swap         = 1'b0;

    if (wr_hs) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == LAST_IDX) wr_done_d = 1'b1;
    end
    if (rd_hs) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if (rd_cnt_q == LAST_IDX) rd_done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wbank_d    = 1'b0;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          wr_done_d  = 1'b0;
          rd_done_d  = 1'b0;
          produced_d = '0;
          rd_ts_d    = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (wr_done_q) begin
          swap       = 1'b1;
          produced_d = TS_W'(1);
          state_d    = (T_STEPS == 1) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (wr_done_q && rd_done_q) begin
          swap       = 1'b1;
          produced_d = produced_q + TS_W'(1);
          rd_ts_d    = rd_ts_q + TS_W'(1);
          if (produced_d == TS_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // rd_done rises together with the final cons_valid, so that word is out this cycle.
        if (rd_done_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (swap) begin
      wbank_d   = ~wbank_q;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      wr_done_d = 1'b0;
      rd_done_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments and resets asynchronously; the BRAM contents
  // live outside this block and are never cleared, which is safe because reads only
  // start on a bank after it has been completely written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wbank_q      <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      produced_q   <= '0;
      rd_ts_q      <= '0;
      cons_valid_q <= 1'b0;
      cons_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      produced_q   <= produced_d;
      rd_ts_q      <= rd_ts_d;
      cons_valid_q <= cons_valid_d;
      cons_last_q  <= cons_last_d;
    end
  end

  // Address/data buses are zeroed when their strobe is low so every output reads 0 in reset.
  assign prod_ready  = wr_open;
  assign bram_wren   = wr_hs;
  assign bram_wraddr = wr_hs ? wr_addr : '0;
  assign bram_wrdat  = wr_hs ? prod_data : '0;
  assign bram_ren    = rd_hs;
  assign bram_raddr  = rd_hs ? rd_addr : '0;
  assign cons_valid  = cons_valid_q;
  assign cons_last   = cons_last_q;
  assign cons_data   = cons_valid_q ? bram_rdat : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign rd_ts       = rd_ts_q;

endmodule

// File: tb/tb_spk_buf_pingpong_ctrl.sv
// Scoreboard bench: accepted producer words are queued with their expected timestep and
// last flag; negedge monitors pop on cons_valid and track address/handshake invariants.
`timescale 1ns/1ps
module tb_spk_buf_pingpong_ctrl;
  localparam int WORDS = 4;
  localparam int RW    = 16;
  localparam int AW    = 3;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
    int            ts;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- instance A: WORDS=4, T_STEPS=3 ----------------
  logic          a_start, a_prod_valid, a_prod_ready, a_cons_req, a_cons_valid, a_cons_last;
  logic          a_wren, a_ren, a_busy, a_done;
  logic [RW-1:0] a_prod_data, a_cons_data, a_wrdat, a_rdat;
  logic [AW-1:0] a_wraddr, a_raddr;
  logic [1:0]    a_rd_ts;
  logic [RW-1:0] a_mem [8];

  spk_buf_pingpong_ctrl #(.WORDS(WORDS), .RAM_WIDTH(RW), .T_STEPS(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .prod_valid(a_prod_valid), .prod_data(a_prod_data), .prod_ready(a_prod_ready),
    .cons_req(a_cons_req), .cons_valid(a_cons_valid), .cons_data(a_cons_data),
    .cons_last(a_cons_last), .bram_wren(a_wren), .bram_wraddr(a_wraddr),
    .bram_wrdat(a_wrdat), .bram_ren(a_ren), .bram_raddr(a_raddr), .bram_rdat(a_rdat),
    .busy(a_busy), .done(a_done), .rd_ts(a_rd_ts)
  );

  always @(posedge clk) begin
    if (a_wren) a_mem[a_wraddr] <= a_wrdat;
    if (a_ren)  a_rdat <= a_mem[a_raddr];
  end

  // ---------------- instance B: WORDS=4, T_STEPS=1 ----------------
  logic          b_start, b_prod_valid, b_prod_ready, b_cons_req, b_cons_valid, b_cons_last;
  logic          b_wren, b_ren, b_busy, b_done;
  logic [RW-1:0] b_prod_data, b_cons_data, b_wrdat, b_rdat;
  logic [AW-1:0] b_wraddr, b_raddr;
  logic [0:0]    b_rd_ts;
  logic [RW-1:0] b_mem [8];

  spk_buf_pingpong_ctrl #(.WORDS(WORDS), .RAM_WIDTH(RW), .T_STEPS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .prod_valid(b_prod_valid), .prod_data(b_prod_data), .prod_ready(b_prod_ready),
    .cons_req(b_cons_req), .cons_valid(b_cons_valid), .cons_data(b_cons_data),
    .cons_last(b_cons_last), .bram_wren(b_wren), .bram_wraddr(b_wraddr),
    .bram_wrdat(b_wrdat), .bram_ren(b_ren), .bram_raddr(b_raddr), .bram_rdat(b_rdat),
    .busy(b_busy), .done(b_done), .rd_ts(b_rd_ts)
  );

  always @(posedge clk) begin
    if (b_wren) b_mem[b_wraddr] <= b_wrdat;
    if (b_ren)  b_rdat <= b_mem[b_raddr];
  end

  // ---------------- A monitor ----------------
  exp_t a_sb[$];
  int   a_w, a_r, a_cons, a_done_cnt, a_ts_due_cyc, a_ts_due_val;
  bit   a_run_end, a_abort, a_busy_chk;

  always @(negedge clk) begin
    if (rst) begin
      if (a_busy_chk) begin
        check("a_busy_after_done", 64'(a_busy), 64'(0));
        a_busy_chk = 1'b0;
      end
      if (a_ts_due_cyc == cyc) check("a_swap_timing_rd_ts", 64'(a_rd_ts), 64'(a_ts_due_val));
      if (a_cons_valid) begin
        if (a_sb.size() == 0) check("a_scoreboard_underflow", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = a_sb.pop_front();
          check("a_cons_data", 64'(a_cons_data), 64'(e.data));
          check("a_cons_last", 64'(a_cons_last), 64'(e.last));
          check("a_rd_ts", 64'(a_rd_ts), 64'(e.ts));
        end
        a_cons++;
      end
      if (a_prod_ready) check("a_ready_after_wr_done", 64'(a_w < 4 * (a_rd_ts + 2)), 64'(1));
      if (a_ren) begin
        check("a_raddr", 64'(a_raddr), 64'(((a_r / 4) % 2) * 4 + a_r % 4));
        check("a_ren_within_step", 64'(a_r < 4 * (a_rd_ts + 1)), 64'(1));
        a_r++;
      end
      if (a_wren) begin
        check("a_wraddr", 64'(a_wraddr), 64'(((a_w / 4) % 2) * 4 + a_w % 4));
        if (a_ren) check("a_banks_differ", 64'(a_wraddr[AW-1] != a_raddr[AW-1]), 64'(1));
        if ((a_w % 4 == 3) && (a_w >= 4) && (a_r == 4 * (a_rd_ts + 1))) begin
          a_ts_due_cyc = cyc + 2;
          a_ts_due_val = a_rd_ts + 1;
        end
        a_w++;
      end
      if (a_done) begin
        a_done_cnt++;
        a_run_end  = 1'b1;
        a_busy_chk = 1'b1;
      end
    end
  end

  task automatic a_clear();
    a_sb.delete();
    a_w = 0; a_r = 0; a_cons = 0; a_done_cnt = 0;
    a_ts_due_cyc = -1; a_ts_due_val = 0;
    a_run_end = 1'b0; a_abort = 1'b0; a_busy_chk = 1'b0;
  endtask

  task automatic a_check_zero(input string tag);
    check({tag, "_prod_ready"}, 64'(a_prod_ready), 64'(0));
    check({tag, "_cons_valid"}, 64'(a_cons_valid), 64'(0));
    check({tag, "_cons_data"},  64'(a_cons_data),  64'(0));
    check({tag, "_cons_last"},  64'(a_cons_last),  64'(0));
    check({tag, "_wren"},       64'(a_wren),       64'(0));
    check({tag, "_wraddr"},     64'(a_wraddr),     64'(0));
    check({tag, "_wrdat"},      64'(a_wrdat),      64'(0));
    check({tag, "_ren"},        64'(a_ren),        64'(0));
    check({tag, "_raddr"},      64'(a_raddr),      64'(0));
    check({tag, "_busy"},       64'(a_busy),       64'(0));
    check({tag, "_done"},       64'(a_done),       64'(0));
    check({tag, "_rd_ts"},      64'(a_rd_ts),      64'(0));
  endtask

  // Words 0x10+i; word i belongs to timestep i/4 and is last when i%4 == 3.
  task automatic a_run(input int cons_div, input int stall_at, input int abort_after, input bit poke);
    a_run_end = 1'b0;
    a_abort   = 1'b0;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    fork
      begin : producer
        for (int i = 0; i < 12 && !a_abort; i++) begin
          int n;
          if (i == stall_at) begin
            a_prod_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1;
          end
          a_prod_valid = 1'b1;
          a_prod_data  = RW'(16'h10 + i);
          n = 0;
          @(negedge clk);
          while (!a_prod_ready && !a_abort && n < 500) begin
            n++;
            @(negedge clk);
          end
          if (a_abort) break;
          if (!a_prod_ready) begin
            check("a_producer_timeout", 64'(0), 64'(1));
            break;
          end
          a_sb.push_back('{data: RW'(16'h10 + i), last: (i % 4 == 3), ts: i / 4});
          @(posedge clk); #1;
        end
        a_prod_valid = 1'b0;
      end
      begin : consumer
        int c;
        c = 0;
        while (!a_run_end && !a_abort && c < 3000) begin
          a_cons_req = (c % cons_div == 0);
          @(posedge clk); #1;
          c++;
        end
        a_cons_req = 1'b0;
        if (!a_run_end && !a_abort) check("a_run_timeout", 64'(0), 64'(1));
      end
      begin : control
        if (abort_after > 0) begin
          repeat (abort_after) @(posedge clk);
          #2;
          check("a_busy_before_rst", 64'(a_busy), 64'(1));
          rst = 1'b0;
          a_abort = 1'b1;
          #1;
          a_check_zero("a_async_rst");
        end else if (poke) begin
          repeat (7) @(posedge clk);
          #1 a_start = 1'b1;
          @(posedge clk); #1 a_start = 1'b0;
          repeat (9) @(posedge clk);
          #1 a_start = 1'b1;
          @(posedge clk); #1 a_start = 1'b0;
        end
      end
    join
    if (abort_after == 0) begin
      repeat (3) @(posedge clk);
      check("a_sb_empty", 64'(a_sb.size()), 64'(0));
      check("a_cons_count", 64'(a_cons), 64'(12));
      check("a_write_count", 64'(a_w), 64'(12));
      check("a_read_count", 64'(a_r), 64'(12));
      check("a_done_pulses", 64'(a_done_cnt), 64'(1));
    end
  endtask

  // ---------------- B monitor ----------------
  exp_t b_sb[$];
  int   b_w = 0, b_r = 0, b_cons = 0, b_done_cnt = 0;
  int   b_fill_cyc = -1, b_first_ren_cyc = -1;
  bit   b_run_end = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (b_cons_valid) begin
        if (b_sb.size() == 0) check("b_scoreboard_underflow", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = b_sb.pop_front();
          check("b_cons_data", 64'(b_cons_data), 64'(e.data));
          check("b_cons_last", 64'(b_cons_last), 64'(e.last));
          check("b_rd_ts", 64'(b_rd_ts), 64'(e.ts));
        end
        b_cons++;
      end
      if (b_w == 4 && b_busy) check("b_ready_after_fill", 64'(b_prod_ready), 64'(0));
      if (b_ren) begin
        if (b_first_ren_cyc < 0) b_first_ren_cyc = cyc;
        check("b_raddr", 64'(b_raddr), 64'(b_r));
        b_r++;
      end
      if (b_wren) begin
        if (b_w == 3) b_fill_cyc = cyc;
        b_w++;
      end
      if (b_done) begin
        b_done_cnt++;
        b_run_end = 1'b1;
      end
    end
  end

  task automatic b_run();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    fork
      begin : b_producer
        for (int i = 0; i < 4; i++) begin
          int n;
          b_prod_valid = 1'b1;
          b_prod_data  = RW'(16'h40 + i);
          n = 0;
          @(negedge clk);
          while (!b_prod_ready && n < 500) begin
            n++;
            @(negedge clk);
          end
          if (!b_prod_ready) begin
            check("b_producer_timeout", 64'(0), 64'(1));
            break;
          end
          b_sb.push_back('{data: RW'(16'h40 + i), last: (i == 3), ts: 0});
          @(posedge clk); #1;
        end
        b_prod_valid = 1'b0;
      end
      begin : b_consumer
        int c;
        c = 0;
        b_cons_req = 1'b1;
        while (!b_run_end && c < 1000) begin
          @(posedge clk); #1;
          c++;
        end
        b_cons_req = 1'b0;
        if (!b_run_end) check("b_run_timeout", 64'(0), 64'(1));
      end
    join
    repeat (3) @(posedge clk);
    check("b_first_ren_after_swap", 64'(b_first_ren_cyc), 64'(b_fill_cyc + 2));
    check("b_read_count", 64'(b_r), 64'(4));
    check("b_cons_count", 64'(b_cons), 64'(4));
    check("b_done_pulses", 64'(b_done_cnt), 64'(1));
    check("b_sb_empty", 64'(b_sb.size()), 64'(0));
    check("b_busy_idle", 64'(b_busy), 64'(0));
  endtask

  initial begin
    rst = 1'b0;
    a_start = 1'b0; a_prod_valid = 1'b1; a_prod_data = 16'hA5A5; a_cons_req = 1'b1;
    b_start = 1'b0; b_prod_valid = 1'b0; b_prod_data = '0;       b_cons_req = 1'b0;
    a_clear();
    repeat (3) @(posedge clk);
    #1;
    a_check_zero("a_reset");
    check("b_reset_busy", 64'(b_busy), 64'(0));
    check("b_reset_ready", 64'(b_prod_ready), 64'(0));
    a_prod_valid = 1'b0; a_prod_data = '0; a_cons_req = 1'b0;
    @(negedge clk) rst = 1'b1;

    a_run(1, -1, 0, 1'b0);   // basic flow
    a_clear();
    a_run(4, -1, 0, 1'b0);   // slow consumer
    a_clear();
    a_run(1, 6, 0, 1'b0);    // producer stall mid-timestep
    a_clear();
    a_run(1, -1, 12, 1'b0);  // reset mid-RUN
    a_clear();
    a_prod_valid = 1'b0; a_cons_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    a_run(1, -1, 0, 1'b1);   // restart after reset, with start pokes while busy

    b_run();                 // T_STEPS == 1

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
